// File: rtl/eth_tx_framer_if.sv
// Upstream byte stream carried from the frame builder to the framer.
// Signals: i_dval/i_data/i_sop/i_eop/i_err from source, o_rdy back from framer.
interface eth_tx_framer_if;
    logic       i_dval;
    logic [7:0] i_data;
    logic       i_sop;
    logic       i_eop;
    logic       i_err;
    logic       o_rdy;

    modport master (
        output i_dval, i_data, i_sop, i_eop, i_err,
        input  o_rdy
    );

    modport slave (
        input  i_dval, i_data, i_sop, i_eop, i_err,
        output o_rdy
    );
endinterface

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, min-size padding, CRC-32 FCS, IPG.
// Ports: i_clk125, i_rst, up (stream slave), o_txd/o_tx_en/o_tx_er, o_busy, o_underrun.
module eth_tx_framer #(
    parameter int MIN_FRAME    = 60,
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_LEN      = 12
) (
    input  logic             i_clk125,
    input  logic             i_rst,
    eth_tx_framer_if.slave   up,
    output logic [7:0]       o_txd,
    output logic             o_tx_en,
    output logic             o_tx_er,
    output logic             o_busy,
    output logic             o_underrun
);

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IPG
    } state_t;

    state_t      state, state_d;
    logic [7:0]  tmr, tmr_d;
    logic [10:0] cnt, cnt_d;
    logic [31:0] crc, crc_d;
    logic        err_q, err_d;
    logic [7:0]  txd_d;
    logic        en_d, er_d, und_d;
    logic        rdy;
    logic [31:0] crc_base;
    logic [10:0] cnt_base;
    logic [31:0] crc_sh;

    // Reflected CRC-32 (0xEDB88320), one byte LSB first.
    function automatic logic [31:0] crc_byte(
        input logic [31:0] c_in,
        input logic [7:0]  d
    );
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // SFD cycle accepts the first byte, so it starts from a fresh CRC/count.
    assign crc_base = (state == SFD) ? 32'hFFFF_FFFF : crc;
    assign cnt_base = (state == SFD) ? 11'd0 : cnt;
    assign crc_sh   = crc >> {tmr[1:0], 3'b000};

    assign up.o_rdy = rdy && !i_rst;
    assign o_busy   = (state != IDLE);

    // Next-state logic also computes the values the output registers
    // load at the edge, so the wire lags the decision by one cycle.
    always_comb begin
        state_d = state;
        tmr_d   = tmr;
        cnt_d   = cnt;
        crc_d   = crc;
        err_d   = err_q;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        und_d   = 1'b0;
        rdy     = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = up.i_dval && !up.i_sop;
                if (up.i_dval && up.i_sop) begin
                    state_d = PRE;
                    tmr_d   = 8'd1;
                    txd_d   = 8'h55;
                    en_d    = 1'b1;
                end
            end
            PRE: begin
                en_d = 1'b1;
                if (tmr >= 8'(PREAMBLE_LEN)) begin
                    state_d = SFD;
                    txd_d   = 8'hD5;
                end else begin
                    tmr_d = tmr + 8'd1;
                    txd_d = 8'h55;
                end
            end
            SFD, DATA: begin
                rdy  = 1'b1;
                en_d = 1'b1;
                if (up.i_dval) begin
                    txd_d   = up.i_data;
                    crc_d   = crc_byte(crc_base, up.i_data);
                    cnt_d   = (cnt_base == 11'h7FF) ? cnt_base
                                                    : cnt_base + 11'd1;
                    state_d = DATA;
                    if (up.i_eop) begin
                        err_d   = up.i_err;
                        tmr_d   = 8'd0;
                        state_d = (int'(cnt_d) < MIN_FRAME) ? PAD : FCS;
                    end
                end else begin
                    er_d    = 1'b1;
                    und_d   = 1'b1;
                    state_d = DROP;
                end
            end
            PAD: begin
                en_d  = 1'b1;
                crc_d = crc_byte(crc, 8'h00);
                cnt_d = cnt + 11'd1;
                if (int'(cnt_d) >= MIN_FRAME) begin
                    state_d = FCS;
                    tmr_d   = 8'd0;
                end
            end
            FCS: begin
                en_d  = 1'b1;
                // A latched error cancels the inversion: raw CRC goes out.
                txd_d = ~crc_sh[7:0] ^ {8{err_q}};
                tmr_d = tmr + 8'd1;
                if (tmr[1:0] == 2'd3) begin
                    state_d = IPG;
                    tmr_d   = 8'd0;
                end
            end
            DROP: begin
                rdy = 1'b1;
                if (up.i_dval && up.i_eop) begin
                    state_d = IPG;
                    tmr_d   = 8'd0;
                end
            end
            IPG: begin
                if (tmr >= 8'(IPG_LEN - 1)) begin
                    state_d = IDLE;
                    tmr_d   = 8'd0;
                end else begin
                    tmr_d = tmr + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk125 or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            tmr        <= 8'd0;
            cnt        <= 11'd0;
            crc        <= 32'hFFFF_FFFF;
            err_q      <= 1'b0;
            o_txd      <= 8'h00;
            o_tx_en    <= 1'b0;
            o_tx_er    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            state      <= state_d;
            tmr        <= tmr_d;
            cnt        <= cnt_d;
            crc        <= crc_d;
            err_q      <= err_d;
            o_txd      <= txd_d;
            o_tx_en    <= en_d;
            o_tx_er    <= er_d;
            o_underrun <= und_d;
        end
    end

endmodule
